// File: rtl/mul_div_unit_if.sv
// Request/response bundle for mul_div_unit: operand handshake, result handshake, busy.
interface mul_div_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_src1;
    logic [XLEN-1:0]  in_src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: pipelined multiplier plus radix-2 restoring divider.
// Optional MDU_FLUSH_EN adds a flush input that aborts any operation in flight.
module mul_div_unit #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned TAG_W      = 5
) (
    input  logic clk,
    input  logic reset,
`ifdef MDU_FLUSH_EN
    input  logic flush,
`endif
    mul_div_unit_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;
    typedef enum logic [2:0] {
        OP_MUL = 3'd0, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_MOD, OP_MODU, OP_RSVD
    } op_e;

    localparam int unsigned CNT_W = $clog2(XLEN + MUL_STAGES);
    localparam int unsigned PIPE  = (MUL_STAGES > 2) ? MUL_STAGES - 2 : 0;
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN - 2);

    state_e           state_q, state_d;
    op_e              op_q, in_op, mul_op;
    logic [XLEN-1:0]  a_q, b_q, result_q;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
    logic             qneg_q, rneg_q;

    logic             flush_i, accept;
    logic             in_mul, in_div, in_sgn, in_zero, neg1, neg2;
    logic [XLEN-1:0]  mag1, mag2, acc_res;
    logic [XLEN-1:0]  mul_a, mul_b, mul_sel;
    logic             mul_sx;
    logic [2*XLEN-1:0] prod, prod_out;
    logic [XLEN:0]    shifted;
    logic             ge;
    logic [XLEN-1:0]  diff, step_rem, step_quo, fix_res;

`ifdef MDU_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign in_op  = op_e'(bus.in_op);
    assign accept = bus.in_valid && (state_q == S_IDLE) && !flush_i;

    always_comb begin
        in_mul  = (in_op == OP_MUL) || (in_op == OP_MULH) || (in_op == OP_MULHU);
        in_div  = (in_op == OP_DIV) || (in_op == OP_DIVU) || (in_op == OP_MOD) || (in_op == OP_MODU);
        in_sgn  = (in_op == OP_DIV) || (in_op == OP_MOD);
        in_zero = (bus.in_src2 == '0);
        neg1    = in_sgn && bus.in_src1[XLEN-1];
        neg2    = in_sgn && bus.in_src2[XLEN-1];
        mag1    = neg1 ? -bus.in_src1 : bus.in_src1;
        mag2    = neg2 ? -bus.in_src2 : bus.in_src2;
    end

    // Single-stage multiply works straight off the request; deeper pipes use the captured operands.
    always_comb begin
        if (MUL_STAGES == 1) begin
            mul_op = in_op;
            mul_a  = bus.in_src1;
            mul_b  = bus.in_src2;
        end else begin
            mul_op = op_q;
            mul_a  = a_q;
            mul_b  = b_q;
        end
        mul_sx = (mul_op == OP_MULH);
        prod   = {{XLEN{mul_sx & mul_a[XLEN-1]}}, mul_a} * {{XLEN{mul_sx & mul_b[XLEN-1]}}, mul_b};
    end

    if (PIPE == 0) begin : g_nopipe
        assign prod_out = prod;
    end else begin : g_pipe
        logic [2*XLEN-1:0] pipe_q [PIPE];
        always_ff @(posedge clk) begin
            pipe_q[0] <= prod;
            for (int unsigned i = 1; i < PIPE; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign prod_out = pipe_q[PIPE-1];
    end

    assign mul_sel = (mul_op == OP_MUL) ? prod_out[XLEN-1:0] : prod_out[2*XLEN-1:XLEN];

    always_comb begin
        acc_res = '0;
        if (in_mul) begin
            acc_res = mul_sel;
        end else if (in_div && in_zero) begin
            acc_res = ((in_op == OP_DIV) || (in_op == OP_DIVU)) ? '1 : bus.in_src1;
        end
    end

    // One restoring step; the last of the XLEN steps runs in FIX alongside the sign correction.
    always_comb begin
        shifted  = {rem_q, quo_q[XLEN-1]};
        ge       = shifted >= {1'b0, dvs_q};
        diff     = shifted[XLEN-1:0] - dvs_q;
        step_rem = ge ? diff : shifted[XLEN-1:0];
        step_quo = {quo_q[XLEN-2:0], ge};
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
            fix_res = qneg_q ? -step_quo : step_quo;
        end else begin
            fix_res = rneg_q ? -step_rem : step_rem;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (in_mul) begin
                        state_d = (MUL_STAGES == 1) ? S_DONE : S_MUL;
                    end else if (in_div && !in_zero) begin
                        state_d = S_DIV;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL:   if (cnt_q == MUL_LAST) state_d = S_DONE;
            S_DIV:   if (cnt_q == DIV_LAST) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            if ((state_d == state_q) && ((state_q == S_MUL) || (state_q == S_DIV))) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= in_op;
                        a_q      <= bus.in_src1;
                        b_q      <= bus.in_src2;
                        tag_q    <= bus.in_tag;
                        rem_q    <= '0;
                        quo_q    <= mag1;
                        dvs_q    <= mag2;
                        qneg_q   <= neg1 ^ neg2;
                        rneg_q   <= neg1;
                        result_q <= acc_res;
                    end
                end
                S_MUL: begin
                    if (cnt_q == MUL_LAST) begin
                        result_q <= mul_sel;
                    end
                end
                S_DIV: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                end
                S_FIX: begin
                    result_q <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mul_div_unit;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned MUL_STAGES = 2;
    localparam int unsigned TAG_W      = 5;

    logic clk;
    logic reset;
`ifdef MDU_FLUSH_EN
    logic flush;
`endif

    int unsigned total;
    int unsigned passed;
    int unsigned fails;

    logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

    mul_div_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    mul_div_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MDU_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        sp = sa * sb;
        up = ua * ub;
        case (op)
            3'd0: return sp[31:0];
            3'd1: return sp[63:32];
            3'd2: return up[63:32];
            3'd3: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd5: return (b == 0) ? a : 32'(sa % sb);
            3'd6: return (b == 0) ? a : 32'(ua % ub);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int unsigned latency(input logic [2:0] op, input logic [31:0] b);
        if (op <= 3'd2) return MUL_STAGES;
        if (op == 3'd7 || b == 0) return 1;
        return XLEN + 1;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int unsigned hold);
        logic [31:0] exp_r;
        int unsigned exp_lat;
        int unsigned cyc;
        exp_r   = model(op, a, b);
        exp_lat = latency(op, b);
        cyc     = 0;
        @(negedge clk);
        check($sformatf("op%0d in_ready idle", op), 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_src1  = a;
        bus.in_src2  = b;
        bus.in_tag   = tag;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.in_src1 = $urandom;
        bus.in_src2 = $urandom;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.out_valid && cyc < 200);
        check($sformatf("op%0d latency", op), 32'(cyc), 32'(exp_lat));
        check($sformatf("op%0d %h,%h result", op, a, b), bus.out_result, exp_r);
        check($sformatf("op%0d tag", op), 32'(bus.out_tag), 32'(tag));
        check($sformatf("op%0d in_ready at valid", op), 32'(bus.in_ready), 32'd0);
        check($sformatf("op%0d busy at valid", op), 32'(bus.busy), 32'd1);
        for (int unsigned i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 3'($urandom_range(0, 7));
            bus.in_tag   = 5'($urandom_range(0, 31));
            @(negedge clk);
            check("hold result", bus.out_result, exp_r);
            check("hold tag", 32'(bus.out_tag), 32'(tag));
            check("hold out_valid", 32'(bus.out_valid), 32'd1);
            check("hold in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        check("in_ready after handshake", 32'(bus.in_ready), 32'd1);
        check("out_valid after handshake", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic abort_mid_div(input bit use_flush);
        int unsigned seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = 3'd3;
        bus.in_src1  = 32'd100;
        bus.in_src2  = 32'd3;
        bus.in_tag   = 5'd9;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("abort busy before", 32'(bus.busy), 32'd1);
        check("abort out_valid before", 32'(bus.out_valid), 32'd0);
        if (use_flush) begin
`ifdef MDU_FLUSH_EN
            flush = 1'b1;
`endif
        end else begin
            reset = 1'b1;
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
`ifdef MDU_FLUSH_EN
        flush = 1'b0;
`endif
        @(negedge clk);
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        check("abort busy", 32'(bus.busy), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort stale result", 32'(seen), 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        total = 0;
        passed = 0;
        fails = 0;
        reset = 1'b1;
`ifdef MDU_FLUSH_EN
        flush = 1'b0;
`endif
        bus.in_valid  = 1'b0;
        bus.in_op     = 3'd0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset out_result", bus.out_result, 32'd0);
        check("reset out_tag", 32'(bus.out_tag), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5'd7, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
        run_op(3'd2, 32'h8000_0000, 32'h8000_0000, 5'd2, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 5'd3, 1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd4, 0);
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 5'd5, 10);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd6, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd8, 0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        run_op(3'd4, 32'd5, 32'd0, 5'd12, 0);
        run_op(3'd6, 32'd5, 32'd0, 5'd13, 0);
        run_op(3'd7, 32'd5, 32'd3, 5'd14, 0);

        abort_mid_div(1'b0);
`ifdef MDU_FLUSH_EN
        abort_mid_div(1'b1);
`endif
        run_op(3'd6, 32'd100, 32'd7, 5'd15, 0);

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = specials[$urandom_range(0, 5)];
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            run_op(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
